// File: rtl/adder_initiator_if.sv
// Signal bundle between the adder initiator and its environment: operand
// stream in, adder drive/return, result stream out, and the check counters.
interface adder_initiator_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_mismatch;
  logic             cnt_clr;
  logic [CNT_W-1:0] txn_count;
  logic [CNT_W-1:0] err_count;

  // Initiator side
  modport master (
    input  in_valid, in_a, in_b, add_y, out_ready, cnt_clr,
    output in_ready, add_a, add_b, out_valid, out_y, out_mismatch,
           txn_count, err_count
  );

  // Environment side: stimulus source, adder responder and result consumer
  modport slave (
    output in_valid, in_a, in_b, add_y, out_ready, cnt_clr,
    input  in_ready, add_a, add_b, out_valid, out_y, out_mismatch,
           txn_count, err_count
  );
endinterface

// File: rtl/adder_initiator.sv
// Adder initiator: takes an operand pair, drives it to an adder, waits SETTLE
// cycles, samples the adder result, compares it with the expected sum and
// presents result plus mismatch flag. Keeps transaction and error counts.
module adder_initiator #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  adder_initiator_if.master  bus
);

  localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  // Counter is loaded at the input handshake and the capture happens when it is 0,
  // so SETTLE-1 gives exactly SETTLE edges from handshake to sample.
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WIDTH-1:0]  add_a_q, add_a_d;
  logic [WIDTH-1:0]  add_b_q, add_b_d;
  // Expected sum is formed at the handshake so the capture edge only compares.
  logic [WIDTH-1:0]  exp_sum_q, exp_sum_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_y_q, out_y_d;
  logic              mismatch_q, mismatch_d;
  logic [CNT_W-1:0]  txn_q, txn_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              capture_s;
  logic              mismatch_s;

  // Next-state and next-output computation for the whole transaction FSM
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    exp_sum_d   = exp_sum_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    mismatch_d  = mismatch_q;
    txn_d       = txn_q;
    err_d       = err_q;
    capture_s   = 1'b0;
    mismatch_s  = (bus.add_y != exp_sum_q);

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          add_a_d   = bus.in_a;
          add_b_d   = bus.in_b;
          exp_sum_d = bus.in_a + bus.in_b;  // carry dropped by truncation
          wait_d    = WAIT_INIT;
          state_d   = S_SETTLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (wait_q == {WAIT_W{1'b0}}) begin
          capture_s   = 1'b1;
          out_y_d     = bus.add_y;
          mismatch_d  = mismatch_s;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    // Clear wins over a coincident capture; that capture goes uncounted.
    if (bus.cnt_clr) begin
      txn_d = {CNT_W{1'b0}};
      err_d = {CNT_W{1'b0}};
    end else if (capture_s) begin
      txn_d = txn_q + CNT_W'(1);
      if (mismatch_s && (err_q != {CNT_W{1'b1}})) begin
        err_d = err_q + CNT_W'(1);
      end else begin
        err_d = err_q;
      end
    end else begin
      txn_d = txn_q;
      err_d = err_q;
    end

    // Registered decode of the next state only; no input feeds in_ready directly.
    in_ready_d = (state_d == S_IDLE);
  end

  // State and output registers; reset discards any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      wait_q      <= {WAIT_W{1'b0}};
      add_a_q     <= {WIDTH{1'b0}};
      add_b_q     <= {WIDTH{1'b0}};
      exp_sum_q   <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      out_y_q     <= {WIDTH{1'b0}};
      mismatch_q  <= 1'b0;
      txn_q       <= {CNT_W{1'b0}};
      err_q       <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      wait_q      <= wait_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      exp_sum_q   <= exp_sum_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      mismatch_q  <= mismatch_d;
      txn_q       <= txn_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.add_a        = add_a_q;
  assign bus.add_b        = add_b_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_y        = out_y_q;
  assign bus.out_mismatch = mismatch_q;
  assign bus.txn_count    = txn_q;
  assign bus.err_count    = err_q;

endmodule

// File: tb/tb_adder_initiator.sv
// Directed bench for adder_initiator. Three instances: default (SETTLE=1),
// SETTLE=3 for the mid-transaction reset case, and CNT_W=2 for counter limits.
// Each instance has its own adder model with an optional fault offset.
module tb_adder_initiator;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] fault_a;
  logic [31:0] fault_b;
  logic [31:0] fault_c;

  adder_initiator_if #(.WIDTH(32), .CNT_W(16)) ifa ();
  adder_initiator_if #(.WIDTH(32), .CNT_W(16)) ifb ();
  adder_initiator_if #(.WIDTH(32), .CNT_W(2))  ifc ();

  adder_initiator #(.WIDTH(32), .SETTLE(1), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  adder_initiator #(.WIDTH(32), .SETTLE(3), .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  adder_initiator #(.WIDTH(32), .SETTLE(1), .CNT_W(2))  dut_c (.clk(clk), .rst(rst), .bus(ifc));

  // Adder responders (fault offset 1 models a broken adder)
  assign ifa.add_y = ifa.add_a + ifa.add_b + fault_a;
  assign ifb.add_y = ifb.add_a + ifb.add_b + fault_b;
  assign ifc.add_y = ifc.add_a + ifc.add_b + fault_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    fault_a = 32'd0;
    fault_b = 32'd0;
    fault_c = 32'd1;
    rst     = 1'b1;
    ifa.in_valid = 1'b0; ifa.in_a = 32'd0; ifa.in_b = 32'd0; ifa.out_ready = 1'b0; ifa.cnt_clr = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_a = 32'd0; ifb.in_b = 32'd0; ifb.out_ready = 1'b0; ifb.cnt_clr = 1'b0;
    ifc.in_valid = 1'b0; ifc.in_a = 32'd0; ifc.in_b = 32'd0; ifc.out_ready = 1'b1; ifc.cnt_clr = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_in_ready", 64'(ifa.in_ready), 64'd1);
    check("rst_out_valid", 64'(ifa.out_valid), 64'd0);
    check("rst_add_a", 64'(ifa.add_a), 64'd0);
    check("rst_out_y", 64'(ifa.out_y), 64'd0);
    check("rst_txn", 64'(ifa.txn_count), 64'd0);
    rst = 1'b0;
    tick();

    // 1 Basic: 5 + 7
    ifa.in_valid = 1'b1; ifa.in_a = 32'd5; ifa.in_b = 32'd7;
    tick();
    ifa.in_valid = 1'b0;
    check("basic_add_a", 64'(ifa.add_a), 64'd5);
    check("basic_add_b", 64'(ifa.add_b), 64'd7);
    check("basic_in_ready_busy", 64'(ifa.in_ready), 64'd0);
    check("basic_no_early_valid", 64'(ifa.out_valid), 64'd0);
    tick();
    check("basic_out_valid", 64'(ifa.out_valid), 64'd1);
    check("basic_out_y", 64'(ifa.out_y), 64'd12);
    check("basic_mismatch", 64'(ifa.out_mismatch), 64'd0);
    check("basic_txn", 64'(ifa.txn_count), 64'd1);
    check("basic_err", 64'(ifa.err_count), 64'd0);

    // 4 Backpressure: hold result for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", 64'(ifa.out_valid), 64'd1);
      check("bp_out_y", 64'(ifa.out_y), 64'd12);
      check("bp_in_ready", 64'(ifa.in_ready), 64'd0);
    end
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    check("bp_release_valid", 64'(ifa.out_valid), 64'd0);
    check("bp_release_in_ready", 64'(ifa.in_ready), 64'd1);
    check("hold_add_a", 64'(ifa.add_a), 64'd5);

    // 2 Wrap: carry out of the sum is ignored
    ifa.in_valid = 1'b1; ifa.in_a = 32'hFFFF_FFFF; ifa.in_b = 32'd1;
    tick();
    ifa.in_valid = 1'b0;
    tick();
    check("wrap_out_y", 64'(ifa.out_y), 64'd0);
    check("wrap_mismatch", 64'(ifa.out_mismatch), 64'd0);
    check("wrap_txn", 64'(ifa.txn_count), 64'd2);
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;

    // 3 Fault: adder returns a+b+1
    fault_a = 32'd1;
    ifa.in_valid = 1'b1; ifa.in_a = 32'd10; ifa.in_b = 32'd20;
    tick();
    ifa.in_valid = 1'b0;
    tick();
    check("fault_out_y", 64'(ifa.out_y), 64'd31);
    check("fault_mismatch", 64'(ifa.out_mismatch), 64'd1);
    check("fault_err", 64'(ifa.err_count), 64'd1);
    check("fault_txn", 64'(ifa.txn_count), 64'd3);
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    fault_a = 32'd0;

    // 5 Reset mid-operation with SETTLE=3
    ifb.in_valid = 1'b1; ifb.in_a = 32'd3; ifb.in_b = 32'd4;
    tick();
    ifb.in_valid = 1'b0;
    tick();
    check("mid_in_ready_busy", 64'(ifb.in_ready), 64'd0);
    check("mid_add_a", 64'(ifb.add_a), 64'd3);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(ifb.in_ready), 64'd1);
    check("mid_rst_add_a", 64'(ifb.add_a), 64'd0);
    check("mid_rst_out_valid", 64'(ifb.out_valid), 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_no_capture", 64'(ifb.out_valid), 64'd0);
    end
    check("mid_txn", 64'(ifb.txn_count), 64'd0);
    check("mid_err", 64'(ifb.err_count), 64'd0);

    // SETTLE=3 latency: out_valid three edges after the handshake edge
    ifb.in_valid = 1'b1; ifb.in_a = 32'd100; ifb.in_b = 32'd23;
    tick();
    ifb.in_valid = 1'b0;
    tick();
    check("s3_wait1", 64'(ifb.out_valid), 64'd0);
    tick();
    check("s3_wait2", 64'(ifb.out_valid), 64'd0);
    tick();
    check("s3_valid", 64'(ifb.out_valid), 64'd1);
    check("s3_out_y", 64'(ifb.out_y), 64'd123);
    check("s3_txn", 64'(ifb.txn_count), 64'd1);

    // 6 Counters with CNT_W=2: five faulty transactions, out_ready tied high
    for (int i = 0; i < 5; i++) begin
      ifc.in_valid = 1'b1; ifc.in_a = 32'(i); ifc.in_b = 32'd1;
      tick();
      ifc.in_valid = 1'b0;
      tick();
      check("cnt_mismatch", 64'(ifc.out_mismatch), 64'd1);
      check("cnt_out_y", 64'(ifc.out_y), 64'(i + 2));
      tick();
    end
    check("cnt_err_sat", 64'(ifc.err_count), 64'd3);
    check("cnt_txn_wrap", 64'(ifc.txn_count), 64'd1);

    // cnt_clr coincident with a capture edge
    ifc.in_valid = 1'b1; ifc.in_a = 32'd7; ifc.in_b = 32'd1;
    tick();
    ifc.in_valid = 1'b0;
    ifc.cnt_clr  = 1'b1;
    tick();
    ifc.cnt_clr  = 1'b0;
    check("clr_txn", 64'(ifc.txn_count), 64'd0);
    check("clr_err", 64'(ifc.err_count), 64'd0);
    check("clr_out_valid", 64'(ifc.out_valid), 64'd1);
    check("clr_out_y", 64'(ifc.out_y), 64'd9);
    check("clr_mismatch", 64'(ifc.out_mismatch), 64'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
